writeback_stage: RTL and testbench

- 5th (final) pipeline stage, directly downstream of memory_stage.
- Registers ir5_input/z5_input into the IR5/Z5 stage registers and decodes IR5 into the register-file write port.
- Returns z5_output to memory_stage for store-data forwarding, and raises forwarding hits for the instruction in stage 4.
- Supports pipeline stall (hold) and flush (insert NOP).

---
 rtl/writeback_stage_pkg.sv | 30 +++
 rtl/writeback_stage_dest_decode.sv | 44 ++++
 rtl/writeback_stage.sv | 114 +++++++++++
 tb/tb_writeback_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
// Shared definitions for the writeback stage and anything else that decodes
// instruction destinations (e.g. the hazard unit).
//   - opcode constants for the MIPS-like instruction subset
//   - NOP_INSTR, the instruction loaded into IR5 on reset/flush
//   - instruction field bit positions
package writeback_stage_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_IMM_LO = 6'h08;
    localparam logic [5:0] OP_IMM_HI = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

endpackage

// File: rtl/writeback_stage_dest_decode.sv
// wb_dest_decode
// Decodes an instruction word into the register it writes back to.
// Ports:
//   ir_i     [31:0] instruction word
//   dest_o   [4:0]  destination register (0 when nothing is written)
//   writes_o        instruction class writes the register file
// Parameter LINK_REG: destination used by JAL.
module wb_dest_decode #(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic [31:0] ir_i,
    output logic [4:0]  dest_o,
    output logic        writes_o
);
    import writeback_stage_pkg::*;

    logic [5:0] opcode;
    logic [4:0] rtField;
    logic [4:0] rdField;
    logic       unusedIrBits;

    assign opcode       = ir_i[OPC_MSB:OPC_LSB];
    assign rtField      = ir_i[RT_MSB:RT_LSB];
    assign rdField      = ir_i[RD_MSB:RD_LSB];
    assign unusedIrBits = ^{ir_i[RS_MSB:RS_LSB], ir_i[RD_LSB-1:0]};

    // Stores, branches, jumps and unknown opcodes fall through to "no write".
    always_comb begin
        dest_o   = 5'd0;
        writes_o = 1'b0;
        if (opcode == OP_RTYPE) begin
            dest_o   = rdField;
            writes_o = 1'b1;
        end else if (opcode == OP_LW ||
                     (opcode >= OP_IMM_LO && opcode <= OP_IMM_HI)) begin
            dest_o   = rtField;
            writes_o = 1'b1;
        end else if (opcode == OP_JAL) begin
            dest_o   = LINK_REG;
            writes_o = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage: holds IR5/Z5, drives the register-file write port and
// flags forwarding hits for the instruction sitting in stage 4.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall, flush        hold all stage registers / replace IR5 with NOP
//   ir5_input, z5_input instruction and result from memory_stage
//   ir4_output          stage-4 instruction, compared for forwarding
//   ir5_output, z5_output  stage registers (Z5 also feeds store-data mux)
//   rf_we, rf_waddr, rf_wdata  register-file write port
//   fwd_rs, fwd_rt      IR5 writes stage-4's rs / rt
//   retire_cnt          retired-instruction count (only with WB_RETIRE_CNT_EN)
// Optional feature macro: WB_RETIRE_CNT_EN.
// DATA_W must be at least 32; instruction fields live in bits [31:0].
module writeback_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = writeback_stage_pkg::NOP_INSTR,
    parameter logic [4:0]        LINK_REG  = 5'd31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] ir5_input,
    input  logic [DATA_W-1:0] z5_input,
    input  logic [DATA_W-1:0] ir4_output,
    output logic [DATA_W-1:0] ir5_output,
    output logic [DATA_W-1:0] z5_output,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_rs,
    output logic              fwd_rt
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);
    import writeback_stage_pkg::*;

    logic [DATA_W-1:0] ir5_q, ir5_d;
    logic [DATA_W-1:0] z5_q, z5_d;
    logic              valid_q, valid_d;
    logic [4:0]        dest;
    logic              writes;
    logic              unusedIr4Bits;

    // Next-state selection: flush beats stall, stall beats a normal load.
    always_comb begin
        ir5_d   = ir5_q;
        z5_d    = z5_q;
        valid_d = valid_q;
        if (flush) begin
            ir5_d   = NOP_INSTR;
            z5_d    = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            ir5_d   = ir5_input;
            z5_d    = z5_input;
            valid_d = 1'b1;
        end
    end

    // Stage registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir5_q   <= NOP_INSTR;
            z5_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir5_q   <= ir5_d;
            z5_q    <= z5_d;
            valid_q <= valid_d;
        end
    end

    wb_dest_decode #(
        .LINK_REG (LINK_REG)
    ) u_dest_decode (
        .ir_i     (ir5_q[31:0]),
        .dest_o   (dest),
        .writes_o (writes)
    );

    // r0 is never written, which also makes the NOP encoding harmless.
    assign rf_we      = valid_q & writes & (dest != 5'd0);
    assign rf_waddr   = rf_we ? dest : 5'd0;
    assign rf_wdata   = z5_q;
    assign ir5_output = ir5_q;
    assign z5_output  = z5_q;

    // rf_waddr is zero whenever rf_we is low, so gating by rf_we keeps r0 out.
    assign fwd_rs = rf_we & (rf_waddr == ir4_output[RS_MSB:RS_LSB]);
    assign fwd_rt = rf_we & (rf_waddr == ir4_output[RT_MSB:RT_LSB]);

    assign unusedIr4Bits = ^{ir4_output[DATA_W-1:RS_MSB+1], ir4_output[RT_LSB-1:0]};

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Counts every edge that moves a valid instruction out of the stage,
    // including the edge that flushes it; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= 32'd0;
        end else if (valid_q && !stall) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] ir5In, z5In, ir4In;
    logic [31:0] ir5Out, z5Out, rfWdata;
    logic        rfWe, fwdRs, fwdRt;
    logic [4:0]  rfWaddr;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: what the stage should be holding.
    logic [31:0] mIr, mZ;
    bit          mValid;
    logic [31:0] mCnt;

    writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .ir5_input  (ir5In),
        .z5_input   (z5In),
        .ir4_output (ir4In),
        .ir5_output (ir5Out),
        .z5_output  (z5Out),
        .rf_we      (rfWe),
        .rf_waddr   (rfWaddr),
        .rf_wdata   (rfWdata),
        .fwd_rs     (fwdRs),
        .fwd_rt     (fwdRt)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retireCnt)
`endif
    );

    always #5 clk = ~clk;

    // Destination register an instruction names, or 0 if it writes nothing.
    function automatic int refDest(logic [31:0] ir);
        int op;
        op = int'(ir >> 26);
        if (op == 0)                         return int'((ir >> 11) & 32'h1F);
        if (op == 35 || (op >= 8 && op <= 15)) return int'((ir >> 16) & 32'h1F);
        if (op == 3)                         return 31;
        return 0;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Compares every output with what the reference state implies.
    task automatic checkAll(string tag);
        int   d;
        bit   we;
        d  = refDest(mIr);
        we = mValid && (d != 0);
        checkOutput({tag, ".ir5"},   ir5Out,  mIr);
        checkOutput({tag, ".z5"},    z5Out,   mZ);
        checkOutput({tag, ".wdata"}, rfWdata, mZ);
        checkOutput({tag, ".we"},    32'(rfWe), 32'(we));
        checkOutput({tag, ".waddr"}, 32'(rfWaddr), we ? 32'(d) : 32'd0);
        checkOutput({tag, ".fwdrs"}, 32'(fwdRs),
                    32'(we && d == int'((ir4In >> 21) & 32'h1F)));
        checkOutput({tag, ".fwdrt"}, 32'(fwdRt),
                    32'(we && d == int'((ir4In >> 16) & 32'h1F)));
`ifdef WB_RETIRE_CNT_EN
        checkOutput({tag, ".retire"}, retireCnt, mCnt);
`endif
    endtask

    // Drives one cycle of inputs, advances the reference at the edge, then checks.
    task automatic applyStimulus(string tag, bit rst, bit stl, bit fl,
                                 logic [31:0] ir, logic [31:0] z, logic [31:0] ir4);
        reset = rst; stall = stl; flush = fl;
        ir5In = ir;  z5In  = z;   ir4In = ir4;
        @(posedge clk);
        if (rst) begin
            mIr = 32'h0; mZ = 32'h0; mValid = 0; mCnt = 32'h0;
        end else begin
            if (mValid && !stl) mCnt = mCnt + 32'd1;
            if (fl) begin
                mIr = 32'h0; mZ = 32'h0; mValid = 0;
            end else if (!stl) begin
                mIr = ir; mZ = z; mValid = 1;
            end
        end
        #1;
        checkAll(tag);
    endtask

    function automatic logic [31:0] randInstr();
        logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h0C, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h10, 6'h3F};
        logic [31:0] w;
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 13)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        mIr = 0; mZ = 0; mValid = 0; mCnt = 0;
        reset = 1; stall = 0; flush = 0; ir5In = 0; z5In = 0; ir4In = 0;

        // Reset held two cycles while a real instruction sits on the input.
        applyStimulus("rst0", 1, 0, 0, 32'h012A4020, 32'h55, 32'h0);
        applyStimulus("rst1", 1, 0, 0, 32'h012A4020, 32'h55, 32'h0);
        checkOutput("rst_ir5", ir5Out, 32'h0);
        checkOutput("rst_we",  32'(rfWe), 32'h0);

        // add $8,$9,$10 with stage-4 reading $8 as rs.
        applyStimulus("add", 0, 0, 0, 32'h012A4020, 32'h55, 32'h0100_0000);
        checkOutput("add_waddr", 32'(rfWaddr), 32'd8);
        checkOutput("add_wdata", rfWdata, 32'h55);
        checkOutput("add_fwdrs", 32'(fwdRs), 32'd1);

        applyStimulus("lw",  0, 0, 0, 32'h8C050004, 32'hDEADBEEF, 32'h0005_0000);
        checkOutput("lw_waddr", 32'(rfWaddr), 32'd5);
        checkOutput("lw_fwdrt", 32'(fwdRt), 32'd1);
        applyStimulus("sw",  0, 0, 0, 32'hAC050004, 32'h1234, 32'h0005_0000);
        checkOutput("sw_we", 32'(rfWe), 32'd0);
        applyStimulus("jal", 0, 0, 0, 32'h0C000010, 32'h104, 32'h03E0_0000);
        checkOutput("jal_waddr", 32'(rfWaddr), 32'd31);
        checkOutput("jal_wdata", rfWdata, 32'h104);
        // R-type with rd=0 and stage-4 reading r0 on both operands.
        applyStimulus("rd0", 0, 0, 0, 32'h012A0020, 32'h77, 32'h0);
        checkOutput("rd0_fwdrs", 32'(fwdRs), 32'd0);

        // Three stall cycles with changing inputs must freeze the stage.
        applyStimulus("ld",  0, 0, 0, 32'h012A4020, 32'h99, 32'h0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 0, 1, 0, 32'h8C000000 | 32'(i), 32'(i + 1), 32'h0);
        checkOutput("stall_ir5", ir5Out, 32'h012A4020);
        applyStimulus("flst", 0, 1, 1, 32'h012A4020, 32'h42, 32'h0);
        checkOutput("flst_ir5", ir5Out, 32'h0);
        checkOutput("flst_we",  32'(rfWe), 32'd0);

        // Reset arriving during a stall.
        applyStimulus("ld2",  0, 0, 0, 32'h012A4020, 32'h5, 32'h0);
        applyStimulus("rstst", 1, 1, 0, 32'h012A4020, 32'h6, 32'h0);

        // Interleaved loads, stalls and a flush for the retire count.
        for (int i = 0; i < 13; i++)
            applyStimulus("seq", 0, (i == 3 || i == 7), (i == 10),
                          32'h012A4020, 32'(i), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, s, f;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 9) == 0);
            applyStimulus("rand", r, s, f, randInstr(), $urandom, randInstr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
